// File: rtl/modbus_pkg.sv
// Shared definitions for the Modbus RTU receive framer: FIFO word layout, CRC constants, FSM states.
package modbus_pkg;

    localparam int SOF_BIT = 8;
    localparam int EOF_BIT = 9;
    localparam int ERR_BIT = 10;

    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'hA001;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RECEIVE,
        GAP,
        EMIT
    } state_t;

endpackage

// File: rtl/modbus_crc16.sv
// Modbus CRC-16 (reflected 0xA001) combinational single-byte update.
module modbus_crc16
    import modbus_pkg::*;
(
    input  logic [15:0] i_crc,
    input  logic [7:0]  i_byte,
    output logic [15:0] o_crc
);

    logic [15:0] w_crc;

    always_comb begin
        w_crc = i_crc ^ {8'h00, i_byte};
        for (int i = 0; i < 8; i++) begin
            w_crc = w_crc[0] ? ((w_crc >> 1) ^ CRC_POLY) : (w_crc >> 1);
        end
    end

    assign o_crc = w_crc;

endmodule

// File: rtl/modbus_rtu_framer.sv
// Modbus RTU receive framer: delimits frames by line silence, checks CRC and writes tagged
// data words plus one end-of-frame status marker into the bridge input FIFO.
//
//   state   | meaning
//   INIT    | waiting for t3.5 of silence after reset; bytes discarded
//   IDLE    | between frames; next byte opens a frame
//   RECEIVE | inside a frame, inter-byte silence below t1.5
//   GAP     | silence past t1.5; a byte here is a gap violation
//   EMIT    | t3.5 reached; marker pending until the FIFO has room
module modbus_rtu_framer
    import modbus_pkg::*;
#(
    parameter int T15_CYCLES = 42969,
    parameter int T35_CYCLES = 100260,
    parameter int CNT_WIDTH  = 17,
    parameter int MAX_FRAME  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_err,
    input  logic        fifo_full,
    output logic        fifo_wr,
    output logic [10:0] fifo_data,
    output logic        busy
);

    localparam logic [CNT_WIDTH-1:0] T15_C = CNT_WIDTH'(T15_CYCLES);
    localparam logic [CNT_WIDTH-1:0] T35_C = CNT_WIDTH'(T35_CYCLES);
    localparam logic [8:0]           MAX_C = 9'(MAX_FRAME);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_WIDTH-1:0]  r_sil;
    logic [8:0]            r_cnt;
    logic [15:0]           r_crc;
    logic                  r_err;
    logic                  r_next_err;
    logic                  r_fifo_wr;
    logic [10:0]           r_fifo_data;

    logic [15:0]           w_crc_nxt;
    logic                  w_accept;
    logic                  w_count;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_emit_wr;
    logic                  w_marker_err;
    logic [10:0]           w_data_word;
    logic [10:0]           w_marker_word;

    modbus_crc16 u_crc (
        .i_crc  (r_crc),
        .i_byte (rx_data),
        .o_crc  (w_crc_nxt)
    );

    assign w_accept     = rx_valid && (r_state inside {IDLE, RECEIVE, GAP});
    assign w_count      = w_accept && !fifo_full;
    assign w_push       = w_count && (r_cnt < MAX_C);
    assign w_drop       = w_accept && !w_push;
    assign w_emit_wr    = (r_state == EMIT) && !fifo_full;
    assign w_marker_err = r_err || (r_crc != 16'h0000) || (r_cnt < 9'd4) || (r_cnt > MAX_C);

    // SOF goes on the first byte actually written, so a dropped opener still yields a tagged start.
    always_comb begin
        w_data_word                = '0;
        w_data_word[7:0]           = rx_data;
        w_data_word[SOF_BIT]       = (r_cnt == 9'd0);
        w_marker_word              = '0;
        w_marker_word[7:0]         = r_cnt[7:0];
        w_marker_word[EOF_BIT]     = 1'b1;
        w_marker_word[ERR_BIT]     = w_marker_err;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT:    if (!rx_valid && (r_sil == T35_C)) w_state_nxt = IDLE;
            IDLE:    if (rx_valid) w_state_nxt = RECEIVE;
            RECEIVE: if (!rx_valid && (r_sil >= T15_C)) w_state_nxt = GAP;
            GAP: begin
                if (rx_valid)             w_state_nxt = RECEIVE;
                else if (r_sil == T35_C)  w_state_nxt = EMIT;
            end
            EMIT:    if (!fifo_full) w_state_nxt = IDLE;
            default: w_state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= INIT;
            r_sil       <= '0;
            r_cnt       <= '0;
            r_crc       <= CRC_INIT;
            r_err       <= 1'b0;
            r_next_err  <= 1'b0;
            r_fifo_wr   <= 1'b0;
            r_fifo_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_fifo_wr <= w_push || w_emit_wr;

            if (rx_valid)            r_sil <= '0;
            else if (r_sil != T35_C) r_sil <= r_sil + CNT_WIDTH'(1);

            if (w_push)         r_fifo_data <= w_data_word;
            else if (w_emit_wr) r_fifo_data <= w_marker_word;

            if (w_emit_wr) begin
                r_cnt      <= '0;
                r_crc      <= CRC_INIT;
                r_err      <= r_next_err || rx_valid;
                r_next_err <= 1'b0;
            end else begin
                if ((r_state == EMIT) && rx_valid) r_next_err <= 1'b1;
                if (w_count && (r_cnt != 9'h1FF))  r_cnt <= r_cnt + 9'd1;
                if (w_push)                        r_crc <= w_crc_nxt;
                if (w_drop || (w_accept && rx_err) || ((r_state == GAP) && rx_valid))
                    r_err <= 1'b1;
            end
        end
    end

    assign fifo_wr   = r_fifo_wr;
    assign fifo_data = r_fifo_data;
    assign busy      = r_state inside {RECEIVE, GAP, EMIT};

endmodule

// File: tb/tb_modbus_rtu_framer.sv
// Bench for modbus_rtu_framer: table of frame cases plus hand sequences, scoreboard on FIFO writes.
module tb_modbus_rtu_framer;
    import modbus_pkg::*;

    localparam int T15    = 43;
    localparam int T35    = 101;
    localparam int CW     = 7;
    localparam int MAXF   = 256;
    localparam int SP     = 20;
    localparam int GAP_SP = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_err = 1'b0;
    logic        fifo_full = 1'b0;
    logic        fifo_wr;
    logic [10:0] fifo_data;
    logic        busy;

    always #5 clk = ~clk;

    modbus_rtu_framer #(
        .T15_CYCLES (T15),
        .T35_CYCLES (T35),
        .CNT_WIDTH  (CW),
        .MAX_FRAME  (MAXF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_err    (rx_err),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_data (fifo_data),
        .busy      (busy)
    );

    logic [15:0] ref_crc_in;
    logic [7:0]  ref_byte;
    logic [15:0] ref_crc_out;
    modbus_crc16 u_ref (.i_crc(ref_crc_in), .i_byte(ref_byte), .o_crc(ref_crc_out));

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [10:0] sb[$];
    logic [10:0] sb_exp;
    logic [7:0]  fb[300];
    logic [7:0]  lf[257];
    logic [7:0]  good[8] = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};

    typedef struct {
        int          n;
        logic [7:0]  last;
        int          gap_idx;
        int          full_idx;
        int          err_idx;
        bit          hold;
        logic [10:0] marker;
    } vec_t;
    vec_t vt[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (fifo_wr === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got 0x%0h, expected no write", fifo_data);
            end else begin
                sb_exp = sb.pop_front();
                check("fifo_word", {21'd0, fifo_data}, {21'd0, sb_exp});
            end
        end
    end

    task automatic ref_crc(input int n, output logic [15:0] crc);
        crc = CRC_INIT;
        for (int i = 0; i < n; i++) begin
            ref_crc_in = crc;
            ref_byte   = fb[i];
            #1;
            crc = ref_crc_out;
        end
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic e, input logic full,
                             input logic exp_wr, input logic [10:0] exp_word);
        @(posedge clk); #1;
        rx_data = d; rx_valid = 1'b1; rx_err = e; fifo_full = full;
        if (exp_wr) sb.push_back(exp_word);
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_err = 1'b0; fifo_full = 1'b0;
        @(negedge clk);
        check("byte_latency", {31'd0, fifo_wr}, {31'd0, exp_wr});
    endtask

    // Entered at the negedge after the last byte was captured; k counts capture edges since then.
    task automatic wait_marker(input bit hold, input logic [10:0] exp_marker);
        int k;
        bit seen;
        k = 0;
        seen = 1'b0;
        sb.push_back(exp_marker);
        while (k < 3 * T35 && !seen) begin
            fifo_full = hold && (k + 1 >= T35 + 2) && (k + 1 <= T35 + 11);
            @(negedge clk);
            k++;
            if (fifo_wr === 1'b1) seen = 1'b1;
        end
        fifo_full = 1'b0;
        #1;
        check("marker_seen", {31'd0, seen}, 32'd1);
        check("marker_cycle", k, hold ? T35 + 12 : T35 + 2);
        check("busy_after_marker", {31'd0, busy}, 32'd0);
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic send_frame(input int n, input int spacing, input int gap_idx, input int full_idx,
                              input int err_idx, input bit hold, input logic [10:0] exp_marker);
        logic first;
        logic pushed;
        first = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i > 0) idle((i - 1 == gap_idx) ? GAP_SP - 2 : spacing - 2);
            pushed = (i != full_idx) && (i < MAXF);
            send_byte(fb[i], i == err_idx, i == full_idx, pushed, {2'b00, first && pushed, fb[i]});
            if (pushed) first = 1'b0;
            if (i == 0) check("busy_in_frame", {31'd0, busy}, 32'd1);
        end
        wait_marker(hold, exp_marker);
    endtask

    task automatic load_good();
        for (int i = 0; i < 8; i++) fb[i] = good[i];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] c;

        vt[0] = '{8, 8'h0A, -1, -1, -1, 1'b0, 11'h208};
        vt[1] = '{8, 8'h0B, -1, -1, -1, 1'b0, 11'h608};
        vt[2] = '{8, 8'h0A,  3, -1, -1, 1'b0, 11'h608};
        vt[3] = '{8, 8'h0A, -1,  2, -1, 1'b0, 11'h607};
        vt[4] = '{8, 8'h0A, -1, -1, -1, 1'b1, 11'h208};
        vt[5] = '{3, 8'h00, -1, -1, -1, 1'b0, 11'h603};
        vt[6] = '{8, 8'h0A, -1, -1,  0, 1'b0, 11'h608};

        load_good();
        ref_crc(6, c);
        check("ref_crc_known", {16'd0, c}, 32'h0000_0A84);

        for (int i = 0; i < 254; i++) fb[i] = 8'(i * 37 + 5);
        ref_crc(254, c);
        fb[254] = c[7:0];
        fb[255] = c[15:8];
        fb[256] = 8'h5A;
        for (int i = 0; i < 257; i++) lf[i] = fb[i];

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_fifo_wr", {31'd0, fifo_wr}, 32'd0);
        check("reset_fifo_data", {21'd0, fifo_data}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        idle(T35 + 10);

        for (int v = 0; v < 7; v++) begin
            load_good();
            fb[vt[v].n - 1] = vt[v].last;
            send_frame(vt[v].n, SP, vt[v].gap_idx, vt[v].full_idx, vt[v].err_idx, vt[v].hold, vt[v].marker);
        end

        // Bytes straight after reset are line noise and must be discarded.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) idle(SP - 2);
            send_byte(good[i], 1'b0, 1'b0, 1'b0, 11'h000);
        end
        check("busy_in_init", {31'd0, busy}, 32'd0);
        idle(T35 + 10);
        load_good();
        send_frame(8, SP, -1, -1, -1, 1'b0, 11'h208);

        // Reset in the middle of a frame: partial data already written, no marker afterwards.
        load_good();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) idle(SP - 2);
            send_byte(fb[i], 1'b0, 1'b0, 1'b1, {2'b00, i == 0, fb[i]});
        end
        idle(SP - 2);
        @(posedge clk); #1;
        rx_data = fb[4]; rx_valid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("midrst_fifo_wr", {31'd0, fifo_wr}, 32'd0);
        check("midrst_fifo_data", {21'd0, fifo_data}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        idle(T35 + 10);
        #1;
        check("midrst_no_marker", sb.size(), 0);
        send_frame(8, SP, -1, -1, -1, 1'b0, 11'h208);

        for (int i = 0; i < 257; i++) fb[i] = lf[i];
        send_frame(256, 3, -1, -1, -1, 1'b0, 11'h200);
        send_frame(257, 3, -1, -1, -1, 1'b0, 11'h601);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
